rinst_encoder: RTL
==================

RINST_ENCODER -- requirements
Module: rinst_encoder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter CNT_W, default 16, width of the issued-instruction counter.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  encoder can accept a request.
REQ-007 ALU_OP  input  3  ALU operation to encode.
REQ-008 rs, rt, rd  input  5 each  register indices.
REQ-009 out_valid  output  1  INST holds a valid instruction word.
REQ-010 out_ready  input  1  consumer accepts INST.
REQ-011 INST  output  32  encoded R-type instruction word.
REQ-012 issued  output  CNT_W  count of instructions delivered.
REQ-013 dropped  output  CNT_W  count of filtered requests; SHALL be constant 0 when RINST_ENC_ZERO_RD_FILTER_EN is undefined.

Function
REQ-014 Encoding SHALL be INST = {6'b000000, rs, rt, rd, 5'b00000, FUNC}.
REQ-015 FUNC SHALL follow the ALU_OP mapping 100->100000, 101->100010, 000->100100, 001->100101, 010->100110, 011->100111, 110->101011, 111->000100; all 8 codes are legal.
REQ-016 Accept SHALL occur on a cycle with in_valid && in_ready; the encoded word is written into the FIFO at that edge.
REQ-017 Deliver SHALL occur on a cycle with out_valid && out_ready; the head entry is popped at that edge.
REQ-018 in_ready SHALL be !full, registered from occupancy, with no combinational path from out_ready.
REQ-019 out_valid SHALL be !empty; INST SHALL be the head entry, held stable while out_valid && !out_ready.
REQ-020 Latency: a word accepted at edge N SHALL appear with out_valid=1 after edge N when the FIFO was empty; there is no bypass from input to INST.
REQ-021 A simultaneous accept and deliver SHALL leave occupancy unchanged and preserve order.
REQ-022 When full, no accept SHALL occur even if a deliver happens that cycle; in_ready rises on the following cycle.
REQ-023 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty derive from the MSB and the remaining bits.
REQ-024 issued SHALL increment by 1 per deliver and wrap from 2^CNT_W-1 to 0.
REQ-025 With in_valid=0, in_ready and FIFO contents SHALL be unaffected by ALU_OP, rs, rt and rd.

Reset
REQ-026 rst=1 at an edge SHALL empty the FIFO and zero both pointers, issued and dropped; after that edge out_valid=0, in_ready=1 and INST=0.
REQ-027 rst SHALL override any accept or deliver in the same cycle; in-flight entries are discarded.

Configuration
REQ-028 Macro RINST_ENC_ZERO_RD_FILTER_EN: when defined, an accepted request with rd==0 SHALL be consumed without a FIFO write, and dropped SHALL increment with wrap.
REQ-029 Without RINST_ENC_ZERO_RD_FILTER_EN, rd==0 requests SHALL be encoded and queued normally; the filter logic is absent.

Structure
REQ-030 The shared package rinst_pkg SHALL hold the ALU_OP code constants, the FUNC constants, OPCODE_RTYPE=6'b000000, and the encode function.
REQ-031 Storage SHALL be in sub-module rinst_fifo (push, pop, full, empty, dout); rinst_encoder holds the encoding, the counters and the filter.

Verification
REQ-032 Reset, then accept ALU_OP=100, rs=1, rt=2, rd=3 with out_ready=1 -> INST=32'h00221820 one cycle later; issued becomes 1.
REQ-033 Hold out_ready=0 and push 5 requests at DEPTH=4 -> in_ready=0 after the 4th accept; the 5th is not accepted; drain yields 4 words in order.
REQ-034 Full FIFO, in_valid=1, out_ready=1 on the same cycle -> one pop, no push; in_ready=1 on the next cycle.
REQ-035 Sweep all 8 ALU_OP codes with rs=rt=rd=0 -> INST low 6 bits match REQ-015 and the upper 26 bits are zero.
REQ-036 Assert rst mid-stream with 3 entries queued -> out_valid=0, issued=0 next cycle; no stale word appears afterwards.
REQ-037 With the macro defined, send rd=0 then rd=5 -> only the rd=5 word is delivered; dropped=1 and issued=1.

Source files
------------

// File: rtl/rinst_pkg.sv
// Shared R-type encoding definitions: ALU_OP codes, FUNC codes, word layout and encoder.
package rinst_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned FUNC_W = 6;

   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

   localparam logic [OP_W-1:0] ALU_AND  = 3'b000;
   localparam logic [OP_W-1:0] ALU_OR   = 3'b001;
   localparam logic [OP_W-1:0] ALU_XOR  = 3'b010;
   localparam logic [OP_W-1:0] ALU_NOR  = 3'b011;
   localparam logic [OP_W-1:0] ALU_ADD  = 3'b100;
   localparam logic [OP_W-1:0] ALU_SUB  = 3'b101;
   localparam logic [OP_W-1:0] ALU_SLTU = 3'b110;
   localparam logic [OP_W-1:0] ALU_SLLV = 3'b111;

   localparam logic [FUNC_W-1:0] FUNC_ADD  = 6'b100000;
   localparam logic [FUNC_W-1:0] FUNC_SUB  = 6'b100010;
   localparam logic [FUNC_W-1:0] FUNC_AND  = 6'b100100;
   localparam logic [FUNC_W-1:0] FUNC_OR   = 6'b100101;
   localparam logic [FUNC_W-1:0] FUNC_XOR  = 6'b100110;
   localparam logic [FUNC_W-1:0] FUNC_NOR  = 6'b100111;
   localparam logic [FUNC_W-1:0] FUNC_SLTU = 6'b101011;
   localparam logic [FUNC_W-1:0] FUNC_SLLV = 6'b000100;

   typedef struct packed {
      logic [5:0]        opcode;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  shamt;
      logic [FUNC_W-1:0] func;
   } rinst_word_t;

   function automatic logic [FUNC_W-1:0] alu_func(input logic [OP_W-1:0] op);
      logic [FUNC_W-1:0] f;
      f = FUNC_AND;
      case (op)
         ALU_AND:  f = FUNC_AND;
         ALU_OR:   f = FUNC_OR;
         ALU_XOR:  f = FUNC_XOR;
         ALU_NOR:  f = FUNC_NOR;
         ALU_ADD:  f = FUNC_ADD;
         ALU_SUB:  f = FUNC_SUB;
         ALU_SLTU: f = FUNC_SLTU;
         ALU_SLLV: f = FUNC_SLLV;
         default:  f = FUNC_AND;
      endcase
      return f;
   endfunction

   function automatic logic [INST_W-1:0] encode(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [REG_W-1:0] rd);
      rinst_word_t w;
      w.opcode = OPCODE_RTYPE;
      w.rs     = rs;
      w.rt     = rt;
      w.rd     = rd;
      w.shamt  = '0;
      w.func   = alu_func(op);
      return INST_W'(w);
   endfunction

endpackage

// File: rtl/rinst_fifo.sv
// Instruction-word FIFO with extra-MSB pointers; dout reads as zero while empty.
module rinst_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW:0]   wp;
   logic [AW:0]   rp;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign dout  = empty ? '0 : mem[rp[AW-1:0]];

   // Pointers wrap modulo 2*DEPTH; reset discards anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full)
            wp <= wp + (AW+1)'(1);
         if (pop && !empty)
            rp <= rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push && !full)
         mem[wp[AW-1:0]] <= din;
   end

endmodule

// File: rtl/rinst_encoder.sv
// R-type instruction encoder feeding a FIFO, with issued/dropped counters.
// Optional zero-rd filter enabled by defining RINST_ENC_ZERO_RD_FILTER_EN.
module rinst_encoder
   import rinst_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   ALU_OP,
   input  logic [REG_W-1:0]  rs,
   input  logic [REG_W-1:0]  rt,
   input  logic [REG_W-1:0]  rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] INST,
   output logic [CNT_W-1:0]  issued,
   output logic [CNT_W-1:0]  dropped
);

   logic              full;
   logic              empty;
   logic              accept;
   logic              deliver;
   logic              push;
   logic [INST_W-1:0] word;

   assign word      = encode(ALU_OP, rs, rt, rd);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign accept    = in_valid && !full;
   assign deliver   = out_valid && out_ready;

`ifdef RINST_ENC_ZERO_RD_FILTER_EN
   assign push = accept && (rd != '0);

   // rd==0 requests are consumed here and never reach the FIFO.
   always_ff @(posedge clk) begin
      if (rst)
         dropped <= '0;
      else if (accept && (rd == '0))
         dropped <= dropped + CNT_W'(1);
   end
`else
   assign push    = accept;
   assign dropped = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         issued <= '0;
      else if (deliver)
         issued <= issued + CNT_W'(1);
   end

   rinst_fifo #(
      .DEPTH (DEPTH),
      .W     (INST_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (deliver),
      .din   (word),
      .dout  (INST),
      .full  (full),
      .empty (empty)
   );

endmodule
